// File: rtl/top_proc_pkg.sv
// Shared constants, ALU op codes, FSM states and instruction decode for top_proc.
// TOP_PROC_SHIFT_EN enables the shift instructions.
package top_proc_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

`ifdef TOP_PROC_SHIFT_EN
    localparam logic SHIFT_EN = 1'b1;
`else
    localparam logic SHIFT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_t;

    typedef struct packed {
        alu_op_t alu_op;
        logic    use_imm;
        logic    reg_write;
        logic    is_lw;
        logic    is_sw;
        logic    is_beq;
    } ctrl_t;

    // Anything not recognised falls through with all enables low, i.e. a NOP.
    function automatic ctrl_t decode(input logic [31:0] ir);
        ctrl_t      c;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ir[14:12];
        f7 = ir[31:25];
        c.alu_op    = ALU_ADD;
        c.use_imm   = 1'b0;
        c.reg_write = 1'b0;
        c.is_lw     = 1'b0;
        c.is_sw     = 1'b0;
        c.is_beq    = 1'b0;
        case (ir[6:0])
            OP_R: begin
                c.reg_write = 1'b1;
                case ({f7, f3})
                    {7'h00, 3'b000}: c.alu_op = ALU_ADD;
                    {7'h20, 3'b000}: c.alu_op = ALU_SUB;
                    {7'h00, 3'b111}: c.alu_op = ALU_AND;
                    {7'h00, 3'b110}: c.alu_op = ALU_OR;
                    {7'h00, 3'b100}: c.alu_op = ALU_XOR;
                    {7'h00, 3'b010}: c.alu_op = ALU_SLT;
                    {7'h00, 3'b001}: begin c.alu_op = ALU_SLL; c.reg_write = SHIFT_EN; end
                    {7'h00, 3'b101}: begin c.alu_op = ALU_SRL; c.reg_write = SHIFT_EN; end
                    {7'h20, 3'b101}: begin c.alu_op = ALU_SRA; c.reg_write = SHIFT_EN; end
                    default:         c.reg_write = 1'b0;
                endcase
            end
            OP_I: begin
                c.use_imm   = 1'b1;
                c.reg_write = 1'b1;
                case (f3)
                    3'b000: c.alu_op = ALU_ADD;
                    3'b010: c.alu_op = ALU_SLT;
                    3'b100: c.alu_op = ALU_XOR;
                    3'b110: c.alu_op = ALU_OR;
                    3'b111: c.alu_op = ALU_AND;
                    3'b001: begin
                        c.alu_op    = ALU_SLL;
                        c.reg_write = SHIFT_EN && (f7 == 7'h00);
                    end
                    3'b101: begin
                        c.alu_op    = (f7 == 7'h20) ? ALU_SRA : ALU_SRL;
                        c.reg_write = SHIFT_EN && ((f7 == 7'h00) || (f7 == 7'h20));
                    end
                    default: c.reg_write = 1'b0;
                endcase
            end
            OP_LW: if (f3 == 3'b010) begin
                c.use_imm   = 1'b1;
                c.reg_write = 1'b1;
                c.is_lw     = 1'b1;
            end
            OP_SW: if (f3 == 3'b010) begin
                c.use_imm = 1'b1;
                c.is_sw   = 1'b1;
            end
            OP_BEQ: if (f3 == 3'b000) begin
                c.alu_op = ALU_SUB;
                c.is_beq = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/top_proc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// x0 is never written, so it always reads zero.
module top_proc_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs_q[wa] <= wd;
        end
    end

    assign rd1 = regs_q[ra1];
    assign rd2 = regs_q[ra2];

endmodule

// File: rtl/top_proc.sv
// Multicycle RV32I-subset core, fixed IF/ID/EX/MEM/WB sequence, one instruction per five cycles.
// Define TOP_PROC_SHIFT_EN to build the shifter (SLL/SRL/SRA and immediate forms).
module top_proc
    import top_proc_pkg::*;
#(
    parameter logic [31:0] INITIAL_PC = 32'h00400000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] dReadData,
    output logic [31:0] PC,
    output logic [31:0] dAddress,
    output logic [31:0] dWriteData,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] WriteBackData
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic        zero_q, zero_d;

    logic [31:0] rs1_data, rs2_data;
    logic [31:0] imm_gen, alu_b, alu_res;
    ctrl_t       ctrl;
    logic        rf_we;

    assign ctrl = decode(ir_q);

    top_proc_regfile u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (instr[19:15]),
        .ra2 (instr[24:20]),
        .rd1 (rs1_data),
        .rd2 (rs2_data),
        .we  (rf_we),
        .wa  (ir_q[11:7]),
        .wd  (WriteBackData)
    );

    always_comb begin
        imm_gen = '0;
        case (instr[6:0])
            OP_I, OP_LW: imm_gen = {{20{instr[31]}}, instr[31:20]};
            OP_SW:       imm_gen = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BEQ:      imm_gen = {{19{instr[31]}}, instr[31], instr[7],
                                    instr[30:25], instr[11:8], 1'b0};
            default:     imm_gen = '0;
        endcase
    end

    always_comb begin
        alu_b   = ctrl.use_imm ? imm_q : b_q;
        alu_res = '0;
        case (ctrl.alu_op)
            ALU_ADD: alu_res = a_q + alu_b;
            ALU_SUB: alu_res = a_q - alu_b;
            ALU_AND: alu_res = a_q & alu_b;
            ALU_OR:  alu_res = a_q | alu_b;
            ALU_XOR: alu_res = a_q ^ alu_b;
            ALU_SLT: alu_res = {31'b0, $signed(a_q) < $signed(alu_b)};
`ifdef TOP_PROC_SHIFT_EN
            ALU_SLL: alu_res = a_q << alu_b[4:0];
            ALU_SRL: alu_res = a_q >> alu_b[4:0];
            ALU_SRA: alu_res = $signed(a_q) >>> alu_b[4:0];
`else
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = '0;
`endif
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        alu_out_d = alu_out_q;
        zero_d    = zero_q;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                ir_d    = instr;
                a_d     = rs1_data;
                b_d     = rs2_data;
                imm_d   = imm_gen;
                state_d = S_EX;
            end
            S_EX: begin
                alu_out_d = alu_res;
                zero_d    = (alu_res == 32'd0);
                state_d   = S_MEM;
            end
            S_MEM: state_d = S_WB;
            S_WB: begin
                pc_d    = (ctrl.is_beq && zero_q) ? pc_q + imm_q : pc_q + 32'd4;
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IF;
            pc_q      <= INITIAL_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            alu_out_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            alu_out_q <= alu_out_d;
            zero_q    <= zero_d;
        end
    end

    // Strobes are masked by rst so a reset landing in MEM leaves the RAM untouched.
    assign MemRead       = (state_q == S_MEM) && ctrl.is_lw && !rst;
    assign MemWrite      = (state_q == S_MEM) && ctrl.is_sw && !rst;
    assign rf_we         = (state_q == S_WB) && ctrl.reg_write;
    assign PC            = pc_q;
    assign dAddress      = (state_q == S_EX) ? alu_res : alu_out_q;
    assign dWriteData    = b_q;
    assign WriteBackData = ctrl.is_lw ? dReadData : alu_out_q;

endmodule

// File: tb/tb_top_proc.sv
// Scoreboard bench for top_proc: an ISA-level model predicts each instruction's bus activity,
// a phase-locked monitor compares it against the core; ends with a reset-during-store check.
module tb_top_proc;

    localparam logic [31:0] BASE   = 32'h00400000;
    localparam int          N_EXEC = 300;
    localparam logic [6:0]  T_R = 7'b0110011, T_I = 7'b0010011, T_LW = 7'b0000011,
                            T_SW = 7'b0100011, T_BEQ = 7'b1100011;
`ifdef TOP_PROC_SHIFT_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr, dReadData, PC, dAddress, dWriteData, WriteBackData;
    logic        MemRead, MemWrite;

    always #5 clk = ~clk;

    top_proc #(.INITIAL_PC(BASE)) dut (
        .clk(clk), .rst(rst), .instr(instr), .dReadData(dReadData), .PC(PC),
        .dAddress(dAddress), .dWriteData(dWriteData), .MemRead(MemRead),
        .MemWrite(MemWrite), .WriteBackData(WriteBackData)
    );

    logic [31:0] rom [256];
    logic [31:0] ram [64];
    logic        ram_init = 1'b1;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off[1:0] != 2'b00 || off >= 32'd1024) return 32'h0;
        return rom[off[9:2]];
    endfunction

    always @(posedge clk) instr <= rom_word(PC);

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) ram[i] <= '0;
        end else if (MemWrite) begin
            ram[dAddress[7:2]] <= dWriteData;
        end
        dReadData <= ram[dAddress[7:2]];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, T_R};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], T_SW};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], T_BEQ};
    endfunction

    function automatic logic [31:0] gen_rand();
        logic [4:0]  rd, r1, r2;
        logic [11:0] imm;
        logic [6:0]  f7;
        logic [2:0]  f3;
        int          sel, o;
        rd  = 5'($urandom_range(0, 7));
        r1  = 5'($urandom_range(0, 7));
        r2  = 5'($urandom_range(0, 7));
        imm = 12'($urandom);
        case ($urandom_range(0, 9))
            0, 1: begin
                sel = $urandom_range(0, 9);
                f7  = (sel == 1 || sel == 8) ? 7'h20 : 7'h00;
                case (sel)
                    0, 1: f3 = 3'd0;  2: f3 = 3'd7;  3: f3 = 3'd6;  4: f3 = 3'd4;
                    5:    f3 = 3'd2;  6: f3 = 3'd1;  7, 8: f3 = 3'd5;  default: f3 = 3'd3;
                endcase
                return enc_r(f7, f3, rd, r1, r2);
            end
            2, 3: begin
                case ($urandom_range(0, 5))
                    0: f3 = 3'd0; 1: f3 = 3'd2; 2: f3 = 3'd4; 3: f3 = 3'd6; 4: f3 = 3'd7;
                    default: f3 = 3'd3;
                endcase
                return enc_i(T_I, f3, rd, r1, imm);
            end
            4: begin
                f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
                f3 = $urandom_range(0, 1) ? 3'd5 : 3'd1;
                return enc_i(T_I, f3, rd, r1, {f7[6:2], 2'b00, imm[4:0]} | {f7, 5'd0});
            end
            5: return enc_s(12'(4 * $urandom_range(0, 15)), r2, 5'd0);
            6: return enc_i(T_LW, 3'b010, rd, 5'd0, 12'(4 * $urandom_range(0, 15)));
            7: begin
                o = 4 * int'($urandom_range(1, 8));
                if ($urandom_range(0, 1) == 1) o = -o;
                return enc_b(13'(o), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            end
            8: return {25'($urandom), 7'b0110111};
            default: return enc_i(T_I, 3'd0, rd, 5'd0, 12'($urandom_range(0, 3)));
        endcase
    endfunction

    typedef struct {
        logic [31:0] pc;
        bit          ld;
        bit          st;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          wb;
        logic [31:0] wbv;
    } exp_t;

    exp_t q[$];

    // Architectural model: executes the ROM program instruction by instruction.
    task automatic run_model();
        logic [31:0] x [32];
        logic [31:0] mm [64];
        logic [31:0] pc, ins, a, b, ii, is, ib, res, nxt;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        bit          wr;
        exp_t        e;
        for (int i = 0; i < 32; i++) x[i] = '0;
        for (int i = 0; i < 64; i++) mm[i] = '0;
        pc = BASE;
        for (int n = 0; n < N_EXEC; n++) begin
            ins = rom_word(pc);
            op  = ins[6:0];  f3 = ins[14:12];  f7 = ins[31:25];  rd = ins[11:7];
            a   = x[ins[19:15]];
            b   = x[ins[24:20]];
            ii  = {{20{ins[31]}}, ins[31:20]};
            is  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            e.pc = pc; e.ld = 0; e.st = 0; e.addr = 0; e.wdata = 0; e.wb = 0; e.wbv = 0;
            wr = 0; res = 0; nxt = pc + 4;
            if (op == T_R) begin
                wr = 1;
                case ({f7, f3})
                    {7'h00, 3'd0}: res = a + b;
                    {7'h20, 3'd0}: res = a - b;
                    {7'h00, 3'd7}: res = a & b;
                    {7'h00, 3'd6}: res = a | b;
                    {7'h00, 3'd4}: res = a ^ b;
                    {7'h00, 3'd2}: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    {7'h00, 3'd1}: begin res = a << b[4:0]; wr = SH; end
                    {7'h00, 3'd5}: begin res = a >> b[4:0]; wr = SH; end
                    {7'h20, 3'd5}: begin res = $unsigned($signed(a) >>> b[4:0]); wr = SH; end
                    default: wr = 0;
                endcase
            end else if (op == T_I) begin
                wr = 1;
                case (f3)
                    3'd0: res = a + ii;
                    3'd2: res = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
                    3'd4: res = a ^ ii;
                    3'd6: res = a | ii;
                    3'd7: res = a & ii;
                    3'd1: begin res = a << ii[4:0]; wr = SH && (f7 == 7'h00); end
                    3'd5: begin
                        if (f7 == 7'h20) res = $unsigned($signed(a) >>> ii[4:0]);
                        else res = a >> ii[4:0];
                        wr = SH && (f7 == 7'h00 || f7 == 7'h20);
                    end
                    default: wr = 0;
                endcase
            end else if (op == T_LW && f3 == 3'd2) begin
                e.ld = 1; e.addr = a + ii; res = mm[e.addr[7:2]]; wr = 1;
            end else if (op == T_SW && f3 == 3'd2) begin
                e.st = 1; e.addr = a + is; e.wdata = b; mm[e.addr[7:2]] = b;
            end else if (op == T_BEQ && f3 == 3'd0) begin
                if (a == b) nxt = pc + ib;
            end
            if (wr && rd != 5'd0) begin
                x[rd] = res; e.wb = 1; e.wbv = res;
            end
            q.push_back(e);
            pc = nxt;
        end
    endtask

    int   phase;
    bit   mon_en   = 1'b0;
    bit   have_cur = 1'b0;
    exp_t cur;
    int   txn = 0;

    always @(posedge clk) begin
        if (rst) phase <= 0;
        else     phase <= (phase == 4) ? 0 : phase + 1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            case (phase)
                0: begin
                    have_cur = (q.size() > 0);
                    if (have_cur) begin
                        cur = q.pop_front();
                        chk("pc_if", PC, cur.pc);
                    end
                end
                1: if (have_cur) chk("strobe_id", {30'b0, MemRead, MemWrite}, 32'd0);
                3: if (have_cur) begin
                    chk("memread", {31'b0, MemRead}, {31'b0, cur.ld});
                    chk("memwrite", {31'b0, MemWrite}, {31'b0, cur.st});
                    if (cur.st) begin
                        chk("st_addr", dAddress, cur.addr);
                        chk("st_data", dWriteData, cur.wdata);
                    end
                    if (cur.ld) chk("ld_addr", dAddress, cur.addr);
                end
                4: if (have_cur) begin
                    chk("strobe_wb", {30'b0, MemRead, MemWrite}, 32'd0);
                    if (cur.wb) chk("wb_data", WriteBackData, cur.wbv);
                    $display("txn %0d pc=%h wb=%h", txn, cur.pc, WriteBackData);
                    txn++;
                end
                default: ;
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = '0;
        rom[0]  = enc_i(T_I, 3'd0, 5'd1, 5'd0, 12'd5);
        rom[1]  = enc_i(T_I, 3'd0, 5'd2, 5'd0, 12'd7);
        rom[2]  = enc_s(12'd8, 5'd2, 5'd0);
        rom[3]  = enc_i(T_LW, 3'b010, 5'd3, 5'd0, 12'd8);
        rom[4]  = enc_i(T_I, 3'd0, 5'd1, 5'd0, 12'd3);
        rom[5]  = enc_i(T_I, 3'd0, 5'd2, 5'd0, 12'd3);
        rom[6]  = enc_b(13'd16, 5'd2, 5'd1);
        rom[7]  = enc_i(T_I, 3'd0, 5'd7, 5'd0, 12'd99);
        rom[8]  = enc_i(T_I, 3'd0, 5'd7, 5'd0, 12'd99);
        rom[9]  = enc_i(T_I, 3'd0, 5'd7, 5'd0, 12'd99);
        rom[10] = enc_i(T_I, 3'd0, 5'd2, 5'd0, 12'd4);
        rom[11] = enc_b(13'd16, 5'd2, 5'd1);
        rom[12] = enc_i(T_I, 3'd0, 5'd1, 5'd0, 12'hFFF);
        rom[13] = enc_i(T_I, 3'd0, 5'd2, 5'd0, 12'd1);
        rom[14] = enc_r(7'h20, 3'd0, 5'd3, 5'd1, 5'd2);
        rom[15] = enc_r(7'h00, 3'd2, 5'd4, 5'd1, 5'd2);
        rom[16] = enc_i(T_I, 3'd5, 5'd5, 5'd1, 12'h404);
        rom[17] = enc_i(T_I, 3'd0, 5'd0, 5'd0, 12'd9);
        rom[18] = enc_r(7'h00, 3'd0, 5'd6, 5'd0, 5'd0);
        for (int i = 19; i < 200; i++) rom[i] = gen_rand();
        run_model();

        rst = 1'b1; ram_init = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pc", PC, BASE);
        chk("rst_daddr", dAddress, 32'd0);
        chk("rst_wdata", dWriteData, 32'd0);
        chk("rst_wb", WriteBackData, 32'd0);
        chk("rst_strobes", {30'b0, MemRead, MemWrite}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; ram_init = 1'b0; mon_en = 1'b1;

        for (int c = 0; c < N_EXEC * 5 + 50 && q.size() != 0; c++) @(negedge clk);
        repeat (6) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        mon_en = 1'b0;

        // Reset asserted in the MEM cycle of a store must suppress the write.
        rom[0] = enc_i(T_I, 3'd0, 5'd2, 5'd0, 12'd7);
        rom[1] = enc_s(12'd200, 5'd2, 5'd0);
        rom[2] = 32'h0;
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1; rst = 1'b0;
        repeat (9) @(negedge clk);
        chk("sw_mem_strobe", {31'b0, MemWrite}, 32'd1);
        chk("sw_mem_addr", dAddress, 32'd200);
        rst = 1'b1; #1;
        chk("sw_rst_gated", {31'b0, MemWrite}, 32'd0);
        @(negedge clk);
        chk("abort_pc", PC, BASE);
        chk("abort_memwrite", {31'b0, MemWrite}, 32'd0);
        chk("abort_ram", ram[50], 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("restart_wb", WriteBackData, 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
